// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer.
// No logic; pure declarations.
// Optional breakpoint support (RUN_SEQ_BREAKPOINT_EN) uses the S_PAUSE encoding.
package run_seq_pkg;

  // Sequencer states; S_PAUSE is only reachable when breakpoints are compiled in.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  // Width of the core-reset hold counter; covers RST_CYC up to 15.
  localparam int HOLD_W = 4;

  // Default RUN cycle limit before a run is aborted.
  localparam logic [15:0] TIMEOUT_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Latency: count value updates on the edge after clr/en is sampled.
// No backpressure: clr has priority over en; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: clear wins, otherwise count up until all-ones and hold there.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register with asynchronous reset to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/run_sequencer.sv
// Run controller: turns harness req into hold-reset / run / drain / done for the core.
// Latency: req to first core_en is 1+RST_CYC cycles; halt to done is 2 cycles.
// No backpressure; req is level-sensitive and only sampled in IDLE and DONE.
// Optional: define RUN_SEQ_BREAKPOINT_EN to add a PC breakpoint with PAUSE/resume.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int            D       = 12,
  parameter int            CW      = 16,
  parameter int            RST_CYC = 2,
  parameter logic [CW-1:0] TIMEOUT = CW'(TIMEOUT_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          halt,
  input  logic [D-1:0]  prog_ctr,
`ifdef RUN_SEQ_BREAKPOINT_EN
  input  logic          bp_valid,
  input  logic [D-1:0]  bp_addr,
  input  logic          resume,
  output logic          paused,
`endif
  output logic          core_reset,
  output logic          core_en,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  // Hold counter value on the last HOLD cycle, and cycle_cnt value on the last allowed RUN cycle.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYC - 1);
  localparam logic [CW-1:0]     RUN_LAST  = TIMEOUT - CW'(1);

  state_t state_q, state_d;

  logic core_reset_q, core_reset_d;
  logic core_en_q,    core_en_d;
  logic busy_q,       busy_d;
  logic done_q,       done_d;
  logic timeout_q,    timeout_d;

  logic              start;
  logic              at_limit;
  logic              bp_hit;
  logic              run_cnt_en;
  logic              hold_en;
  logic [HOLD_W-1:0] hold_cnt;

  assign start    = (state_q == S_IDLE) && req;
  assign at_limit = (cycle_cnt == RUN_LAST);

`ifdef RUN_SEQ_BREAKPOINT_EN
  logic mask_q, mask_d;
  logic paused_q, paused_d;

  // A match stops the core in the same cycle so the instruction at bp_addr is not
  // executed; halt and timeout take priority, and the first cycle after resume is masked.
  assign bp_hit = (state_q == S_RUN) && bp_valid && (prog_ctr == bp_addr) &&
                  !mask_q && !halt && !at_limit;
`else
  logic unused_prog_ctr;
  assign unused_prog_ctr = ^prog_ctr;
  assign bp_hit          = 1'b0;
`endif

  assign hold_en    = (state_q == S_HOLD);
  assign run_cnt_en = (state_q == S_RUN) && !bp_hit;

  sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk (clk),
    .rst (reset),
    .clr (start),
    .en  (hold_en),
    .q   (hold_cnt)
  );

  sat_counter #(.W(CW)) u_cycle_cnt (
    .clk (clk),
    .rst (reset),
    .clr (start),
    .en  (run_cnt_en),
    .q   (cycle_cnt)
  );

  // Next-state and timeout-flag logic; halt beats the cycle limit, which beats a breakpoint.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d   = S_HOLD;
          timeout_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_DRAIN;
        end else if (at_limit) begin
          state_d   = S_DRAIN;
          timeout_d = 1'b1;
        end else if (bp_hit) begin
          state_d = S_PAUSE;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        if (!req) state_d = S_IDLE;
      end
      S_PAUSE: begin
`ifdef RUN_SEQ_BREAKPOINT_EN
        if (resume) state_d = S_RUN;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they register alongside it.
  always_comb begin
    core_reset_d = (state_d == S_IDLE) || (state_d == S_HOLD);
    core_en_d    = (state_d == S_RUN);
    busy_d       = (state_d == S_HOLD) || (state_d == S_RUN) ||
                   (state_d == S_DRAIN) || (state_d == S_PAUSE);
    done_d       = (state_d == S_DONE);
  end

  // State and output registers; reset parks the core in reset with everything idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      core_reset_q <= 1'b1;
      core_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_reset_q <= core_reset_d;
      core_en_q    <= core_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

`ifdef RUN_SEQ_BREAKPOINT_EN
  // Breakpoint mask for the first RUN cycle after resume, plus the registered paused flag.
  always_comb begin
    mask_d   = (state_q == S_PAUSE) && (state_d == S_RUN);
    paused_d = (state_d == S_PAUSE);
  end

  // Breakpoint bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      paused_q <= paused_d;
    end
  end

  assign paused  = paused_q;
  assign core_en = core_en_q && !bp_hit;
`else
  assign core_en = core_en_q;
`endif

  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Run controller for the 9-bit-ISA core. Converts the harness `req` into a sequenced core run: hold core reset, enable execution, detect halt, and report `done`.
- Sits between the top-level `req`/`done` pins and the core's PC/register/memory enables.
- Also counts executed cycles and aborts runaway programs with a timeout.

Parameters:
- D, 12, program counter width (matches PC/instr_ROM).
- CW, 16, cycle counter width.
- RST_CYC, 2, number of cycles core_reset is held after a start; legal range 1..15.
- TIMEOUT, 16'hFFFF, RUN cycle limit before forced abort; must fit in CW bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  start request from harness; level-sensitive.
- halt  in  1  core's Control asserts for one cycle when the halt/done opcode is decoded.
- prog_ctr  in  D  current PC value; used only by the optional feature.
- core_reset  out  1  drives PC/core reset.
- core_en  out  1  global enable for PC advance, RegWrite and MemWrite.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  run complete.
- timeout  out  1  qualifies done: run was aborted by TIMEOUT.
- cycle_cnt  out  CW  RUN cycles of the current or last run.

Behaviour:
- All outputs are registered (Moore). Reset values: state=IDLE, core_reset=1, core_en=0, busy=0, done=0, timeout=0, cycle_cnt=0.
- Asserting reset at any time, including mid-run, forces IDLE with these values asynchronously.
- States: IDLE, HOLD, RUN, DRAIN, DONE.
- IDLE:
  - core_reset=1, core_en=0.
  - req=1 -> HOLD; clear cycle_cnt, timeout and the hold counter on the same edge.
- HOLD:
  - core_reset=1, busy=1.
  - Hold counter increments each cycle. After exactly RST_CYC cycles in HOLD -> RUN.
- RUN:
  - core_reset=0, core_en=1, busy=1.
  - cycle_cnt increments by 1 per cycle.
  - halt=1 -> DRAIN; cycle_cnt includes the halt cycle.
  - cycle_cnt==TIMEOUT-1 with halt=0 -> DRAIN, and set timeout=1.
  - halt and the timeout condition in the same cycle: halt wins, timeout stays 0.
  - cycle_cnt saturates and never wraps.
- DRAIN:
  - One cycle with core_en=0 so the last writeback settles; busy=1.
  - Always -> DONE.
- DONE:
  - done=1, busy=0, core_en=0, core_reset=0 (core state stays readable).
  - cycle_cnt and timeout hold their values.
  - req=0 -> IDLE; done falls on the next edge.
  - req still 1 -> remain in DONE. No auto-restart: a new run needs req to go low, then high.
- req falling during HOLD, RUN or DRAIN is ignored; the run completes.
- halt outside RUN is ignored.
- Latency:
  - req high to first core_en=1 is 1+RST_CYC cycles.
  - halt to done=1 is 2 cycles.

Optional Feature:
- Macro: RUN_SEQ_BREAKPOINT_EN.
- Enabled:
  - Adds ports bp_valid (in 1), bp_addr (in D), resume (in 1), paused (out 1).
  - Adds state PAUSE.
  - In RUN, if bp_valid && prog_ctr==bp_addr -> PAUSE on the next edge. The instruction at bp_addr is not executed.
  - PAUSE: core_en=0, paused=1, cycle_cnt frozen.
  - resume=1 -> RUN. The breakpoint match is masked for the first RUN cycle after resume so execution can step past it.
  - reset from PAUSE -> IDLE.
- Disabled: these ports and the PAUSE state do not exist; behaviour is exactly as above.

Decomposition:
- Package run_seq_pkg:
  - State enum (IDLE, HOLD, RUN, DRAIN, DONE, PAUSE), 3-bit encoding.
  - localparam for hold-counter width (4).
  - Default TIMEOUT constant.
- Sub-module sat_counter (parameter W): synchronous clear, enable, saturate at all-ones, async reset. Instantiated for both the hold counter and cycle_cnt.

Test Plan:
- Reset then idle, req=0 for 10 cycles -> core_reset=1, core_en=0, done=0, busy=0 throughout.
- req=1 at cycle 0 with RST_CYC=2 -> core_reset high through cycle 2, core_en=1 from cycle 3; halt pulse in the 5th RUN cycle -> done=1 two cycles later, cycle_cnt=5, timeout=0.
- TIMEOUT=8, halt never asserted -> after 8 RUN cycles done=1, timeout=1, cycle_cnt=8; halt and limit coincident -> timeout=0.
- req held high after done -> done stays 1 and no restart; req low one cycle then high -> new run, cycle_cnt cleared to 0.
- Assert reset in the 3rd RUN cycle -> core_reset=1, core_en=0, cycle_cnt=0 immediately (before the next clk edge).
- With RUN_SEQ_BREAKPOINT_EN: bp_addr=12'h004, PC reaches 4 -> paused=1, core_en=0, cycle_cnt frozen for 6 cycles; resume pulse -> PC advances past 4 and the run finishes normally.
